// File: rtl/sar_pkg.sv
// sar_pkg: definitions shared by the successive-approximation search
// controller and its comparator plant.
//   sar_state_t   - controller state encoding (IDLE, PROBE, DONE)
//   iter_w()      - width of a counter that can hold 0..width probes
//   flags_onehot()- true when exactly one of gt/eq/lt is asserted
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } sar_state_t;

  function automatic int iter_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic flags_onehot(input logic gt, input logic eq, input logic lt);
    return ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) ||
           ({gt, eq, lt} == 3'b001);
  endfunction

endpackage

// File: rtl/sar_comparator.sv
// sar_comparator: unsigned magnitude comparator used as the plant that
// the search controller probes.
// Ports:
//   i_a  - trial operand (driven by the controller)
//   i_b  - unknown target
//   o_gt - i_a >  i_b
//   o_eq - i_a == i_b
//   o_lt - i_a <  i_b
module sar_comparator #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/sar_search.sv
// sar_search: successive-approximation controller. Drives a trial operand
// onto comparator input A, reads back gt/eq/lt and converges on the
// target on input B one bit per probe, MSB first.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   start     - begin a search; only accepted in IDLE
//   trial     - operand driven to comparator input A
//   gt/eq/lt  - comparator flags (trial vs target)
//   busy      - search in progress (set on accept, cleared after DONE)
//   done      - one-cycle pulse, result/found/err/iters valid
//   result    - recovered target value
//   found     - search ended on an eq hit
//   err       - flags not one-hot at a sample point
//   iters     - number of probes sampled by the last search
//   dbg_state - current FSM state for observation
// Handshake: start is a request sampled on every rising edge; it is taken
// only when the FSM is in IDLE (busy=0 and not in the DONE cycle). The
// done pulse is the single-cycle response; outputs hold afterwards until
// the next accepted start.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 0,
  localparam int ITER_W = iter_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WIDTH-1:0]  trial,
  input  logic              gt,
  input  logic              eq,
  input  logic              lt,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              found,
  output logic              err,
  output logic [ITER_W-1:0] iters,
  output logic [1:0]        dbg_state
);

  localparam int K_W   = $clog2(WIDTH);
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  sar_state_t        r_state;
  sar_state_t        w_next_state;

  logic [WIDTH-1:0]  r_acc;
  logic [K_W-1:0]    r_k;
  logic [WIDTH-1:0]  r_trial;
  logic [SET_W-1:0]  r_settle;
  logic [WIDTH-1:0]  r_result;
  logic              r_found;
  logic              r_err;
  logic [ITER_W-1:0] r_iters;
  logic              r_busy;

  logic              w_sample;
  logic              w_onehot;
  logic [WIDTH-1:0]  w_next_acc;
  logic [WIDTH-1:0]  w_next_bit;

  // Flags are only trusted once the settle window has elapsed.
  assign w_sample   = (r_state == PROBE) && (r_settle == '0);
  assign w_onehot   = flags_onehot(gt, eq, lt);
  // lt means trial is still below the target, so the probed bit stays set.
  assign w_next_acc = lt ? r_trial : r_acc;
  // Only used when r_k > 0, so the wrap of r_k-1 at k==0 is harmless.
  assign w_next_bit = ONE << (r_k - 1'b1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = PROBE;
      end
      PROBE: begin
        if (w_sample && (!w_onehot || eq || (r_k == '0))) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    done      = (r_state == DONE);
    busy      = r_busy;
    trial     = r_trial;
    result    = r_result;
    found     = r_found;
    err       = r_err;
    iters     = r_iters;
    dbg_state = r_state;
  end

  // Search datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_k      <= '0;
      r_trial  <= '0;
      r_settle <= '0;
      r_result <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_iters  <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc    <= '0;
            r_k      <= K_W'(WIDTH - 1);
            r_trial  <= ONE << (WIDTH - 1);
            r_settle <= SET_W'(SETTLE);
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_iters  <= '0;
            r_busy   <= 1'b1;
          end
        end
        PROBE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - 1'b1;
          end else begin
            r_iters <= r_iters + ITER_W'(1);
            if (!w_onehot) begin
              r_err    <= 1'b1;
              r_result <= r_acc;
            end else if (eq) begin
              r_result <= r_trial;
              r_found  <= 1'b1;
            end else begin
              r_acc <= w_next_acc;
              if (r_k == '0) begin
                r_result <= w_next_acc;
              end else begin
                r_k      <= r_k - 1'b1;
                r_trial  <= w_next_acc | w_next_bit;
                r_settle <= SET_W'(SETTLE);
              end
            end
          end
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
